// File: rtl/rv32im_pkg.sv
// rtl/rv32im_pkg.sv - shared RV32IM pipeline types and constants
package rv32im_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MISS,
        REDIRECT
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_pipeline_reg.sv
// rtl/if_id_pipeline_reg.sv - IF/ID pipeline register with load / hold / bubble
module if_id_pipeline_reg
    import rv32im_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [XLEN-1:0] instruction_out,
    output logic            valid_out
);

    // A bubble keeps the PC fields so downstream debug still sees the last real PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out          <= '0;
            pc_plus4_out    <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (bubble) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (load) begin
            pc_out          <= pc;
            pc_plus4_out    <= pc_plus4;
            instruction_out <= instruction;
            valid_out       <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32IM instruction fetch stage; IF_PERF_CNT_EN adds fetch/miss counters
module if_stage
    import rv32im_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_TARGET,
    output logic            IMEM_READ,
    output logic [XLEN-1:0] IMEM_ADDRESS,
    input  logic [XLEN-1:0] IMEM_READDATA,
    input  logic            IMEM_BUSYWAIT,
    output logic [XLEN-1:0] PC_OUT,
    output logic [XLEN-1:0] PC_PLUS4_OUT,
    output logic [XLEN-1:0] INSTRUCTION_OUT,
    output logic            VALID_OUT
`ifdef IF_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] FETCH_COUNT,
    output logic [XLEN-1:0] MISS_CYCLE_COUNT
`endif
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pending_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_load;
    logic            ifid_bubble;

    assign target       = word_align(BRANCH_TARGET);
    assign pc_plus4     = pc + INSTR_BYTES;
    assign IMEM_ADDRESS = pc;

    // A redirect always flushes IF/ID, even over a stall.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (BRANCH_TAKEN) begin
            ifid_bubble = 1'b1;
        end else if (!STALL) begin
            case (state)
                FETCH, MISS: begin
                    ifid_bubble = IMEM_BUSYWAIT;
                    ifid_load   = !IMEM_BUSYWAIT;
                end
                REDIRECT: ifid_bubble = 1'b1;
                default:  ifid_bubble = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            pending_target <= '0;
            IMEM_READ      <= 1'b0;
        end else begin
            IMEM_READ <= 1'b1;
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (BRANCH_TAKEN) pc <= target;
                end
                FETCH: begin
                    if (BRANCH_TAKEN) begin
                        // The cache cannot abort, so a busy read must drain first.
                        if (IMEM_BUSYWAIT) begin
                            pending_target <= target;
                            state          <= REDIRECT;
                        end else begin
                            pc <= target;
                        end
                    end else if (IMEM_BUSYWAIT) begin
                        state <= MISS;
                    end else if (!STALL) begin
                        pc <= pc_plus4;
                    end
                end
                MISS: begin
                    if (BRANCH_TAKEN) begin
                        pending_target <= target;
                        state          <= REDIRECT;
                    end else if (!IMEM_BUSYWAIT) begin
                        state <= FETCH;
                        if (!STALL) pc <= pc_plus4;
                    end
                end
                REDIRECT: begin
                    if (BRANCH_TAKEN) pending_target <= target;
                    if (!IMEM_BUSYWAIT) begin
                        pc    <= BRANCH_TAKEN ? target : pending_target;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_pipeline_reg u_if_id (
        .clk             (CLK),
        .rst             (RESET),
        .load            (ifid_load),
        .bubble          (ifid_bubble),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instruction     (IMEM_READDATA),
        .pc_out          (PC_OUT),
        .pc_plus4_out    (PC_PLUS4_OUT),
        .instruction_out (INSTRUCTION_OUT),
        .valid_out       (VALID_OUT)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FETCH_COUNT      <= '0;
            MISS_CYCLE_COUNT <= '0;
        end else begin
            if (ifid_load) FETCH_COUNT <= FETCH_COUNT + 32'd1;
            if (state == MISS || state == REDIRECT) MISS_CYCLE_COUNT <= MISS_CYCLE_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS4_OUT;
    logic [31:0] INSTRUCTION_OUT;
    logic        VALID_OUT;
`ifdef IF_PERF_CNT_EN
    logic [31:0] FETCH_COUNT;
    logic [31:0] MISS_CYCLE_COUNT;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model of the fetch stage
    logic        m_started;
    logic        m_in_miss;
    logic        m_redir;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] m_pc_out;
    logic [31:0] m_pc4_out;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_fetches;
    logic [31:0] m_miss_cycles;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .STALL           (STALL),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .IMEM_READ       (IMEM_READ),
        .IMEM_ADDRESS    (IMEM_ADDRESS),
        .IMEM_READDATA   (IMEM_READDATA),
        .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
        .PC_OUT          (PC_OUT),
        .PC_PLUS4_OUT    (PC_PLUS4_OUT),
        .INSTRUCTION_OUT (INSTRUCTION_OUT),
        .VALID_OUT       (VALID_OUT)
`ifdef IF_PERF_CNT_EN
        ,
        .FETCH_COUNT     (FETCH_COUNT),
        .MISS_CYCLE_COUNT(MISS_CYCLE_COUNT)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started     = 1'b0;
        m_in_miss     = 1'b0;
        m_redir       = 1'b0;
        m_pc          = 32'h0;
        m_tgt         = 32'h0;
        m_pc_out      = 32'h0;
        m_pc4_out     = 32'h0;
        m_instr       = NOP;
        m_valid       = 1'b0;
        m_fetches     = 32'h0;
        m_miss_cycles = 32'h0;
    endtask

    task automatic check_outputs();
        check("imem_read", {31'b0, IMEM_READ}, {31'b0, m_started});
        check("imem_addr", IMEM_ADDRESS, m_pc);
        check("pc_out", PC_OUT, m_pc_out);
        check("pc_plus4", PC_PLUS4_OUT, m_pc4_out);
        check("instr", INSTRUCTION_OUT, m_instr);
        check("valid", {31'b0, VALID_OUT}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", FETCH_COUNT, m_fetches);
        check("miss_cnt", MISS_CYCLE_COUNT, m_miss_cycles);
`endif
    endtask

    // One clock edge of fetch behaviour, given this cycle's inputs.
    task automatic model_step(input logic br, input logic [31:0] ta, input logic st, input logic bw);
        logic bubble;
        bubble = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
            if (br) begin
                m_pc   = ta;
                bubble = 1'b1;
            end
        end else begin
            if (m_in_miss || m_redir) m_miss_cycles = m_miss_cycles + 32'd1;
            if (m_redir) begin
                if (br) m_tgt = ta;
                bubble = br || !st;
                if (!bw) begin
                    m_pc    = m_tgt;
                    m_redir = 1'b0;
                end
            end else if (br) begin
                bubble = 1'b1;
                if (m_in_miss || bw) begin
                    m_redir = 1'b1;
                    m_tgt   = ta;
                end else begin
                    m_pc = ta;
                end
                m_in_miss = 1'b0;
            end else if (st) begin
                m_in_miss = bw;
            end else if (bw) begin
                bubble    = 1'b1;
                m_in_miss = 1'b1;
            end else begin
                m_pc_out  = m_pc;
                m_pc4_out = m_pc + 32'd4;
                m_instr   = mem_word(m_pc);
                m_valid   = 1'b1;
                m_fetches = m_fetches + 32'd1;
                m_pc      = m_pc + 32'd4;
                m_in_miss = 1'b0;
            end
        end
        if (bubble) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic br, input logic [31:0] tgt, input logic st, input logic bw);
        check_outputs();
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        STALL         = st;
        IMEM_BUSYWAIT = bw;
        model_step(br, {tgt[31:2], 2'b00}, st, bw);
        @(negedge CLK);
    endtask

    // Asserted away from any rising edge, so the #1 check sees the asynchronous path.
    task automatic do_reset();
        RESET         = 1'b1;
        BRANCH_TAKEN  = 1'b0;
        STALL         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        do_reset();

        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0040, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            logic        br, st, bw;
            logic [31:0] tgt;
            br  = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 6) == 0);
            bw  = ($urandom_range(0, 9) < 3);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle(br, tgt, st, bw);
        end

        check_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
